// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit frame arbiter.
// Holds the FSM state encoding, the abort beat values and a saturating counter helper.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } eth_state_e;

    // Beat presented to the MAC when a stalled frame is cut short.
    localparam logic [7:0] ABORT_TDATA = 8'h00;
    localparam logic       ABORT_TLAST = 1'b1;
    localparam logic       ABORT_TUSER = 1'b1;

    localparam logic [15:0] CNT16_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        sat_inc16 = (val == CNT16_MAX) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting port after
// the last granted one, wrapping from NUM_PORTS-1 back to 0.
module eth_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PW-1:0]        i_last,
    output logic [PW-1:0]        o_grant,
    output logic                 o_valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            v_idx = (int'(i_last) + k) % NUM_PORTS;
            if (i_req[v_idx]) begin
                o_grant = PW'(v_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Multiplexes per-requester AXI-Stream byte frames onto one MAC transmit
// stream, whole frames at a time, aborting frames whose source stalls.
module eth_tx_frame_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int STALL_TIMEOUT = 255,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    input  logic [NUM_PORTS-1:0]   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic [NUM_PORTS-1:0]   port_enable,
    output logic                   grant_valid,
    output logic [PW-1:0]          grant_port,
    output logic [15:0]            abort_count
);

    localparam logic [15:0] STALL_LIMIT = 16'(STALL_TIMEOUT - 1);

    eth_state_e           r_state;
    logic [PW-1:0]        r_grant_port;
    logic [PW-1:0]        r_last_ptr;
    logic                 r_grant_valid;
    logic [15:0]          r_stall;
    logic [15:0]          r_abort_cnt;

    logic [NUM_PORTS-1:0] w_req;
    logic [PW-1:0]        w_arb_idx;
    logic                 w_arb_valid;
    logic [7:0]           w_sel_tdata;
    logic                 w_sel_tvalid;
    logic                 w_sel_tlast;
    logic                 w_sel_tuser;
    logic [NUM_PORTS-1:0] w_gnt_onehot;

    assign w_req = s_axis_tvalid & port_enable;

    eth_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_last  (r_last_ptr),
        .o_grant (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_sel_tdata  = '0;
        w_sel_tvalid = 1'b0;
        w_sel_tlast  = 1'b0;
        w_sel_tuser  = 1'b0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant_port == PW'(i)) begin
                w_sel_tdata     = s_axis_tdata[i*8 +: 8];
                w_sel_tvalid    = s_axis_tvalid[i];
                w_sel_tlast     = s_axis_tlast[i];
                w_sel_tuser     = s_axis_tuser[i];
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    // Output steering is combinational so PASS adds no latency to the frame.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_PASS: begin
                m_axis_tdata  = w_sel_tdata;
                m_axis_tvalid = w_sel_tvalid;
                m_axis_tlast  = w_sel_tlast;
                m_axis_tuser  = w_sel_tuser;
                s_axis_tready = w_gnt_onehot & {NUM_PORTS{m_axis_tready}};
            end
            ST_ABORT: begin
                m_axis_tdata  = ABORT_TDATA;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = ABORT_TLAST;
                m_axis_tuser  = ABORT_TUSER;
            end
            ST_DRAIN: begin
                s_axis_tready = w_gnt_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_port  <= '0;
            r_last_ptr    <= PW'(NUM_PORTS - 1);
            r_grant_valid <= 1'b0;
            r_stall       <= '0;
            r_abort_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stall <= '0;
                    if (w_arb_valid) begin
                        r_grant_port  <= w_arb_idx;
                        r_last_ptr    <= w_arb_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    // Backpressure from the MAC is not a stall; only a silent source is.
                    if (w_sel_tvalid) begin
                        if (m_axis_tready) begin
                            r_stall <= '0;
                            if (w_sel_tlast) begin
                                r_state       <= ST_IDLE;
                                r_grant_valid <= 1'b0;
                            end
                        end
                    end else if (r_stall == STALL_LIMIT) begin
                        r_stall <= '0;
                        r_state <= ST_ABORT;
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                ST_ABORT: begin
                    if (m_axis_tready) begin
                        r_abort_cnt <= sat_inc16(r_abort_cnt);
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_sel_tvalid && w_sel_tlast) begin
                        r_state       <= ST_IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_port  = r_grant_port;
    assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: round-robin order, backpressure,
// stall abort and drain, port enable masking and mid-frame reset.
module tb_eth_tx_frame_arbiter;

    localparam int NP = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tready;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tuser;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [1:0]  port_enable;
    logic        grant_valid;
    logic [0:0]  grant_port;
    logic [15:0] abort_count;

    int total = 0;
    int bad   = 0;
    int beat[2];
    int len[2];
    bit on[2];
    bit hold[2];
    bit err[2];

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(
        .NUM_PORTS     (NP),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .port_enable   (port_enable),
        .grant_valid   (grant_valid),
        .grant_port    (grant_port),
        .abort_count   (abort_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source data byte is 0x10*(port+1)+beat so every beat is distinguishable.
    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i]       = on[i] && !hold[i];
            s_tdata[i*8 +: 8] = 8'(16 * (i + 1) + beat[i]);
            s_tlast[i]        = (beat[i] == len[i] - 1);
            s_tuser[i]        = err[i] && (beat[i] == len[i] - 1);
        end
    endtask

    task automatic step();
        logic [1:0] hs;
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (hs[i]) beat[i] = (beat[i] == len[i] - 1) ? 0 : beat[i] + 1;
        drive();
        #1;
    endtask

    task automatic run_frame(input int p, input int n);
        for (int b = 0; b < n; b++) begin
            chk("frame_gvalid", grant_valid, 1);
            chk("frame_gport", grant_port, p);
            chk("frame_mvalid", m_tvalid, 1);
            chk("frame_mdata", m_tdata, 16 * (p + 1) + b);
            chk("frame_mlast", m_tlast, (b == n - 1));
            chk("frame_muser", m_tuser, (err[p] && b == n - 1));
            chk("frame_sready", s_tready, 2'b01 << p);
            step();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mvalid"}, m_tvalid, 0);
        chk({tag, "_gvalid"}, grant_valid, 0);
        chk({tag, "_sready"}, s_tready, 0);
    endtask

    initial begin
        int n;
        int held_bad;
        rst         = 1'b1;
        m_tready    = 1'b1;
        port_enable = 2'b11;
        for (int i = 0; i < 2; i++) begin
            beat[i] = 0; len[i] = 3; on[i] = 0; hold[i] = 0; err[i] = 0;
        end
        drive();
        #1;
        chk_idle("reset_during");
        chk("reset_gport", grant_port, 0);
        chk("reset_abort", abort_count, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk_idle("reset_after");

        // Two ports requesting back to back: P0,P1,P0,P1 with one idle cycle each.
        on[0] = 1; on[1] = 1;
        drive();
        #1;
        for (int f = 0; f < 4; f++) begin
            chk_idle("rr_gap");
            step();
            run_frame(f % 2, 3);
        end
        on[0] = 0; on[1] = 0;
        drive();
        #1;
        chk_idle("rr_done");

        // Long MAC backpressure mid-frame must not trigger an abort.
        on[1] = 1;
        drive();
        #1;
        step();
        chk("bp_gport", grant_port, 1);
        chk("bp_beat0", m_tdata, 8'h20);
        step();
        m_tready = 1'b0;
        #1;
        held_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (!(m_tvalid === 1'b1 && m_tdata === 8'h21 && m_tlast === 1'b0)) held_bad++;
        end
        chk("bp_held_beats", held_bad, 0);
        chk("bp_sready_low", s_tready, 0);
        chk("bp_abort", abort_count, 0);
        m_tready = 1'b1;
        #1;
        chk("bp_beat1", m_tdata, 8'h21);
        step();
        chk("bp_beat2", m_tdata, 8'h22);
        chk("bp_beat2_last", m_tlast, 1);
        step();
        on[1] = 0;
        drive();
        #1;
        chk_idle("bp_done");
        chk("bp_abort_end", abort_count, 0);

        // Port 0 goes silent after two beats of a five-beat frame.
        len[0] = 5;
        on[0]  = 1;
        drive();
        #1;
        step();
        chk("st_gport", grant_port, 0);
        step();
        step();
        hold[0] = 1;
        drive();
        #1;
        chk("st_silent_mvalid", m_tvalid, 0);
        n = 0;
        while (m_tvalid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("st_stall_cycles", n, TO);
        chk("st_abort_data", m_tdata, 8'h00);
        chk("st_abort_last", m_tlast, 1);
        chk("st_abort_user", m_tuser, 1);
        chk("st_abort_sready", s_tready, 0);
        chk("st_abort_gvalid", grant_valid, 1);
        chk("st_abort_cnt_pre", abort_count, 0);
        step();
        chk("st_abort_cnt", abort_count, 1);
        chk("st_drain_mvalid", m_tvalid, 0);
        chk("st_drain_sready", s_tready, 2'b01);
        hold[0] = 0;
        drive();
        #1;
        chk("st_drain_hidden", m_tvalid, 0);
        step();
        step();
        chk("st_drain_last_sready", s_tready, 2'b01);
        chk("st_drain_src_last", s_tlast[0], 1);
        step();
        on[0] = 0;
        len[0] = 3;
        drive();
        #1;
        chk_idle("st_done");
        chk("st_abort_final", abort_count, 1);

        // Port 0 masked: port 1 wins twice; tuser passes through.
        port_enable = 2'b10;
        on[0] = 1; on[1] = 1; err[1] = 1;
        drive();
        #1;
        step();
        run_frame(1, 3);
        err[1] = 0;
        drive();
        #1;
        chk_idle("en_gap");
        step();
        run_frame(1, 3);
        // Re-enable port 0, then mask it again once its frame has started.
        port_enable = 2'b11;
        #1;
        step();
        chk("en_p0_gport", grant_port, 0);
        port_enable = 2'b10;
        #1;
        run_frame(0, 3);
        chk_idle("en_gap2");
        step();
        chk("en_p1_gport", grant_port, 1);
        chk("en_p1_beat0", m_tdata, 8'h20);
        step();

        // Reset in the middle of port 1's frame.
        rst = 1'b1;
        #1;
        chk("rst_sready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_gvalid", grant_valid, 0);
        chk("rst_gport", grant_port, 0);
        chk("rst_abort", abort_count, 0);
        step();
        beat[0] = 0;
        beat[1] = 0;
        port_enable = 2'b11;
        drive();
        rst = 1'b0;
        #1;
        chk_idle("rst_idle");
        step();
        run_frame(0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of transmit requesters (2..8).
REQ-002 SHALL have parameter STALL_TIMEOUT, default 255, idle cycles of the granted requester before the frame is aborted (1..65535).
REQ-003 SHALL have port clk  input  1  single clock, same domain as MAC tx_clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser  input/input/output/input/input  NUM_PORTS*8/NUM_PORTS each  per-requester 8-bit frame streams, port i in slice i.
REQ-006 SHALL have ports m_axis_tdata/tvalid/tready/tlast/tuser  output/output/input/output/output  8/1/1/1/1  stream to MAC tx_axis.
REQ-007 SHALL have port port_enable  input  NUM_PORTS  per-requester arbitration enable.
REQ-008 SHALL have ports grant_valid  output  1, grant_port  output  $clog2(NUM_PORTS)  current owner of the output.
REQ-009 SHALL have port abort_count  output  16  number of frames aborted by stall timeout.

Function
REQ-010 SHALL implement states IDLE, PASS, ABORT, DRAIN.
REQ-011 IDLE: when any port has tvalid and port_enable set, SHALL grant the first such port after the last granted one (round-robin, wrapping NUM_PORTS-1 -> 0) and enter PASS next cycle; grant_valid=1 from that cycle.
REQ-012 IDLE: all s_axis_tready=0 and m_axis_tvalid=0.
REQ-013 PASS: output SHALL be a zero-latency combinational mux of the granted port: m_axis_tdata/tvalid/tlast/tuser = granted inputs, granted tready = m_axis_tready, all other treadies 0.
REQ-014 PASS: handshake with tlast=1 SHALL return to IDLE next cycle; grant held until then (no interleaving within a frame).
REQ-015 Deasserting port_enable mid-frame SHALL NOT affect the current frame; it only excludes the port from the next arbitration.
REQ-016 PASS: a stall counter SHALL increment each cycle the granted tvalid=0, clear on every handshake or state exit, and never count cycles where tvalid=1 and m_axis_tready=0.
REQ-017 Stall counter reaching STALL_TIMEOUT SHALL move to ABORT next cycle.
REQ-018 ABORT: m_axis_tvalid=1, tdata=0x00, tlast=1, tuser=1, granted tready=0; on m_axis_tready enter DRAIN.
REQ-019 DRAIN: m_axis_tvalid=0, granted tready=1; discard beats until a tlast handshake, then IDLE; no timeout in DRAIN.
REQ-020 abort_count SHALL increment by 1 on ABORT exit and saturate at 0xFFFF.
REQ-021 Last-granted pointer SHALL update on grant; abort does not alter round-robin order.
REQ-022 Exactly one idle cycle (IDLE) SHALL separate consecutive output frames.
REQ-023 tuser=1 from a requester SHALL pass through unchanged in PASS.

Reset
REQ-024 rst SHALL force state IDLE, stall counter 0, abort_count 0, last-granted pointer NUM_PORTS-1 (port 0 wins first), grant_valid 0, grant_port 0.
REQ-025 During and after reset all s_axis_tready and m_axis_tvalid SHALL be 0 until a grant; reset mid-frame truncates the output frame without an abort beat.

Structure
REQ-026 State enum and abort beat constants SHALL live in shared package eth_pkg.
REQ-027 Round-robin selection SHALL be a sub-module eth_rr_arbiter (request vector, last pointer -> grant index, valid), combinational.

Verification
REQ-028 Ports 0 and 1 both request continuously with 3-beat frames -> output order P0,P1,P0,P1, one idle cycle between frames, grant_port toggles.
REQ-029 Port 1 mid-frame, m_axis_tready low 1000 cycles -> no abort, abort_count 0, frame intact.
REQ-030 Port 0 stalls tvalid=0 for STALL_TIMEOUT=16 cycles after beat 2 -> beat 0x00 tlast=1 tuser=1 emitted, remaining port-0 beats drained to its tlast, abort_count=1, then IDLE.
REQ-031 port_enable=2'b10 with both valid -> only port 1 granted; clearing bit 0 mid-frame of port 0 -> that frame completes.
REQ-032 rst pulsed during PASS -> next cycle state IDLE, all treadies 0, m_axis_tvalid 0, port 0 wins next arbitration.
